// File: rtl/pipe_stage_elastic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic
// Description : Two-entry elastic pipeline stage (main + skid register) with
//               a fully registered up_ready_o, synchronous flush and a
//               saturating backpressure (stall) counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       asynchronous, active-low reset
//   flush_i      in   1       synchronous kill of all held entries
//   up_valid_i   in   1       upstream payload valid
//   up_data_i    in   DATA_W  upstream payload
//   up_ready_o   out  1       stage can accept this cycle
//   dn_valid_o   out  1       downstream payload valid
//   dn_data_o    out  DATA_W  downstream payload (main register)
//   dn_ready_i   in   1       downstream accepts this cycle
//   occ_o        out  2       entries held (0..2)
//   stall_cnt_o  out  CNT_W   saturating count of backpressured cycles
//   clr_cnt_i    in   1       synchronous clear of stall_cnt_o
// ============================================================================
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              up_ready_o,
  output logic              dn_valid_o,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              dn_ready_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              clr_cnt_i
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q,  main_d;
  logic [DATA_W-1:0]   skid_q,  skid_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic accept;
  logic pop;

  // Handshake outputs come straight from the state register, so there is
  // no combinational path from dn_ready_i to up_ready_o.
  assign up_ready_o  = (state_q != FULL);
  assign dn_valid_o  = (state_q != EMPTY);
  assign occ_o       = state_q;
  assign dn_data_o   = main_q;
  assign stall_cnt_o = stall_cnt_q;

  assign accept = up_valid_i & up_ready_o;
  assign pop    = dn_valid_o & dn_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = up_data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({accept, pop})
          2'b10: begin
            skid_d  = up_data_i;
            state_d = FULL;
          end
          2'b11: begin
            main_d  = up_data_i;
          end
          2'b01: begin
            // main keeps its stale value; only valid drops.
            state_d = EMPTY;
          end
          default: begin
          end
        endcase
      end
      FULL: begin
        // up_ready_o is low here, so accept cannot occur.
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush wins over any concurrent transfer; payload registers are frozen
    // so only the valid indication is cleared.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt_i) begin
      stall_cnt_d = '0;
    end else if (dn_valid_o && !dn_ready_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_elastic
// Description : Directed and randomised self-checking bench for
//               pipe_stage_elastic (CNT_W reduced to 4 for saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_elastic;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk_i;
  logic              rst_i;
  logic              flush_i;
  logic              up_valid_i;
  logic [DATA_W-1:0] up_data_i;
  logic              up_ready_o;
  logic              dn_valid_o;
  logic [DATA_W-1:0] dn_data_o;
  logic              dn_ready_i;
  logic [1:0]        occ_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              clr_cnt_i;

  int n_vec;
  int n_err;

  pipe_stage_elastic #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .up_valid_i  (up_valid_i),
    .up_data_i   (up_data_i),
    .up_ready_o  (up_ready_o),
    .dn_valid_o  (dn_valid_o),
    .dn_data_o   (dn_data_o),
    .dn_ready_i  (dn_ready_i),
    .occ_o       (occ_o),
    .stall_cnt_o (stall_cnt_o),
    .clr_cnt_i   (clr_cnt_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [DATA_W-1:0] sb_q[$];

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_i      = 1'b1;
    flush_i    = 1'b0;
    up_valid_i = 1'b0;
    up_data_i  = '0;
    dn_ready_i = 1'b0;
    clr_cnt_i  = 1'b0;

    // Reset asserted before any clock edge: outputs must respond at once.
    #2 rst_i = 1'b0;
    #1;
    chk("rst_occ",    occ_o,       0);
    chk("rst_dvalid", dn_valid_o,  0);
    chk("rst_ddata",  dn_data_o,   0);
    chk("rst_uready", up_ready_o,  1);
    chk("rst_stall",  stall_cnt_o, 0);

    // Release between edges (t=22); first accept on the next edge.
    #19 rst_i = 1'b1;

    // Streaming 1..4 with downstream always ready.
    dn_ready_i = 1'b1;
    up_valid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      up_data_i = DATA_W'(i);
      tick();
      chk("stream_data",   dn_data_o,  i);
      chk("stream_occ",    occ_o,      1);
      chk("stream_uready", up_ready_o, 1);
    end
    up_valid_i = 1'b0;
    tick();
    chk("stream_drain_occ", occ_o,       0);
    chk("stream_stall",     stall_cnt_o, 0);

    // Backpressure: A, B fill the stage, C is held off.
    dn_ready_i = 1'b0;
    up_valid_i = 1'b1;
    up_data_i  = 32'hA;
    tick();
    chk("bp_a_occ",  occ_o,     1);
    chk("bp_a_data", dn_data_o, 32'hA);
    up_data_i = 32'hB;
    tick();
    chk("bp_full_occ",    occ_o,       2);
    chk("bp_full_uready", up_ready_o,  0);
    chk("bp_full_data",   dn_data_o,   32'hA);
    chk("bp_full_stall",  stall_cnt_o, 1);
    up_data_i = 32'hC;
    tick();
    chk("bp_hold_occ",   occ_o,       2);
    chk("bp_hold_data",  dn_data_o,   32'hA);
    chk("bp_hold_stall", stall_cnt_o, 2);
    dn_ready_i = 1'b1;
    tick();
    chk("bp_out_b",     dn_data_o, 32'hB);
    chk("bp_out_b_occ", occ_o,     1);
    tick();
    chk("bp_out_c",     dn_data_o, 32'hC);
    chk("bp_out_c_occ", occ_o,     1);
    up_valid_i = 1'b0;
    tick();
    chk("bp_drain_occ", occ_o,       0);
    chk("bp_stall_tot", stall_cnt_o, 2);

    // Flush while full, with a concurrent upstream valid.
    dn_ready_i = 1'b0;
    up_valid_i = 1'b1;
    up_data_i  = 32'h11;
    tick();
    up_data_i = 32'h22;
    tick();
    chk("fl_pre_occ", occ_o, 2);
    flush_i   = 1'b1;
    up_data_i = 32'h33;
    tick();
    chk("fl_occ",    occ_o,      0);
    chk("fl_dvalid", dn_valid_o, 0);
    chk("fl_uready", up_ready_o, 1);
    chk("fl_data",   dn_data_o,  32'h11);
    flush_i    = 1'b0;
    up_valid_i = 1'b0;
    dn_ready_i = 1'b1;
    tick();
    chk("fl_after_occ",    occ_o,      0);
    chk("fl_after_dvalid", dn_valid_o, 0);

    // Saturation of the 4-bit stall counter.
    clr_cnt_i = 1'b1;
    tick();
    chk("sat_clr0", stall_cnt_o, 0);
    clr_cnt_i  = 1'b0;
    dn_ready_i = 1'b0;
    up_valid_i = 1'b1;
    up_data_i  = 32'h55;
    tick();
    up_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_val", stall_cnt_o, 15);
    chk("sat_occ", occ_o,       1);
    clr_cnt_i = 1'b1;
    tick();
    chk("sat_clr", stall_cnt_o, 0);
    clr_cnt_i = 1'b0;

    // Asynchronous reset mid-operation while full.
    up_valid_i = 1'b1;
    up_data_i  = 32'h66;
    tick();
    chk("ar_pre_occ", occ_o, 2);
    up_valid_i = 1'b0;
    #3 rst_i = 1'b0;
    #1;
    chk("ar_dvalid", dn_valid_o,  0);
    chk("ar_occ",    occ_o,       0);
    chk("ar_stall",  stall_cnt_o, 0);
    chk("ar_data",   dn_data_o,   0);
    chk("ar_uready", up_ready_o,  1);
    @(negedge clk_i);
    rst_i      = 1'b1;
    up_valid_i = 1'b1;
    up_data_i  = 32'hDEADBEEF;
    dn_ready_i = 1'b1;
    tick();
    chk("ar_post_dvalid", dn_valid_o, 1);
    chk("ar_post_data",   dn_data_o,  32'hDEADBEEF);
    up_valid_i = 1'b0;
    tick();
    chk("ar_post_drain", occ_o, 0);

    // Random traffic against a scoreboard queue.
    sb_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic exp_ready;
      logic acc;
      logic pp;
      up_valid_i = 1'($urandom_range(0, 1));
      dn_ready_i = 1'($urandom_range(0, 1));
      up_data_i  = DATA_W'($urandom);
      exp_ready  = (sb_q.size() < 2);
      chk("rnd_occ",    occ_o,      sb_q.size());
      chk("rnd_uready", up_ready_o, exp_ready);
      chk("rnd_dvalid", dn_valid_o, (sb_q.size() != 0));
      if (sb_q.size() != 0) chk("rnd_data", dn_data_o, sb_q[0]);
      acc = up_valid_i & exp_ready;
      pp  = (sb_q.size() != 0) & dn_ready_i;
      if (pp)  void'(sb_q.pop_front());
      if (acc) sb_q.push_back(up_data_i);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits.
REQ-002 SHALL have parameter CNT_W, default 16: stall-counter width in bits.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  synchronous kill of all held entries.
REQ-006 SHALL have port up_valid_i  input  1  upstream payload valid.
REQ-007 SHALL have port up_data_i  input  DATA_W  upstream payload.
REQ-008 SHALL have port up_ready_o  output  1  stage can accept this cycle.
REQ-009 SHALL have port dn_valid_o  output  1  downstream payload valid.
REQ-010 SHALL have port dn_data_o  output  DATA_W  downstream payload, driven from the main register.
REQ-011 SHALL have port dn_ready_i  input  1  downstream accepts this cycle.
REQ-012 SHALL have port occ_o  output  2  entries held: 0, 1 or 2.
REQ-013 SHALL have port stall_cnt_o  output  CNT_W  saturating count of backpressured cycles.
REQ-014 SHALL have port clr_cnt_i  input  1  synchronous clear of stall_cnt_o.

Function
REQ-015 SHALL hold two registered entries, main and skid; states EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
REQ-016 SHALL define accept = up_valid_i & up_ready_o and pop = dn_valid_o & dn_ready_i.
REQ-017 SHALL drive up_ready_o = (state != FULL), from registered state only, with no combinational path from dn_ready_i.
REQ-018 SHALL drive dn_valid_o = (state != EMPTY) and occ_o = state encoding.
REQ-019 EMPTY: on accept, main <= up_data_i and go to ONE; otherwise hold.
REQ-020 ONE with accept and no pop: skid <= up_data_i, go to FULL.
REQ-021 ONE with accept and pop: main <= up_data_i, stay in ONE.
REQ-022 ONE with pop and no accept: go to EMPTY; main keeps its stale value.
REQ-023 FULL with pop: main <= skid, go to ONE; without pop: hold both entries.
REQ-024 SHALL preserve order: no payload overtakes an earlier one; no payload is duplicated or lost except by flush.
REQ-025 Latency SHALL be 1 cycle: data accepted at edge N is visible on dn_data_o after edge N.
REQ-026 Throughput SHALL be 1 payload per cycle while dn_ready_i=1.
REQ-027 flush_i=1 SHALL force the state to EMPTY at the next edge, overriding any concurrent accept or pop; the accepted payload is dropped.
REQ-028 dn_data_o and the skid register SHALL keep their values on flush; only valid is cleared.
REQ-029 stall_cnt_o SHALL increment by 1 on each cycle with dn_valid_o=1 and dn_ready_i=0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-030 clr_cnt_i SHALL take priority over increment, setting stall_cnt_o to 0 at the next edge.
REQ-031 flush_i SHALL NOT modify stall_cnt_o.
REQ-032 up_data_i SHALL be ignored whenever accept=0.

Reset
REQ-033 While rst_i=0, the block SHALL immediately force: state EMPTY, main=0, skid=0, stall_cnt_o=0; hence dn_valid_o=0, dn_data_o=0, occ_o=0, up_ready_o=1.
REQ-034 Reset asserted mid-operation SHALL discard all held entries with no partial transfer, regardless of clock.
REQ-035 The first accept SHALL be possible on the first rising edge after rst_i rises.

Verification
REQ-036 Streaming: up_valid_i=1 with data 1,2,3,4 on consecutive cycles and dn_ready_i=1 throughout -> dn_data_o = 1,2,3,4 one cycle later; occ_o stays 1; up_ready_o stays 1.
REQ-037 Backpressure: send A then B with dn_ready_i=0 -> occ_o=2, up_ready_o=0, C held off; then raise dn_ready_i -> outputs A, B, C in order; stall_cnt_o equals the number of stalled cycles.
REQ-038 Flush: occ_o=2 with flush_i=1 and up_valid_i=1 in the same cycle -> next cycle occ_o=0, dn_valid_o=0, up_ready_o=1; the new payload is not emitted.
REQ-039 Saturation: CNT_W=4, hold dn_valid_o=1 with dn_ready_i=0 for 20 cycles -> stall_cnt_o=15; then clr_cnt_i=1 for one cycle -> stall_cnt_o=0.
REQ-040 Async reset: occ_o=2, drop rst_i between clock edges -> dn_valid_o=0, occ_o=0 and stall_cnt_o=0 immediately; after release, one payload 0xDEADBEEF is accepted and emitted after 1 cycle.
REQ-041 Random: random up_valid_i and dn_ready_i over 10k cycles against a scoreboard queue -> no loss, duplication or reorder; occ_o never exceeds 2.
